// File: rtl/float_acc_ctrl.sv
// float_acc_ctrl
//   Streams a vector of IEEE-754 single-precision operands through one
//   combinational float adder and returns the sum. One operand is accepted
//   per cycle. The result is held on out_data/out_valid until it is accepted.
//
//   Optional feature macro: FLOAT_ACC_BIAS_EN
//     When defined, this adds the 'bias' input, which is sampled with start.
//     It also adds a BIAS state that adds bias to the sum before the result
//     is presented. This costs one extra cycle of latency.
//
//   Ports
//     clk        system clock, rising edge
//     rst        synchronous active-high reset
//     start      request a new accumulation (sampled only in IDLE)
//     len        number of elements, sampled with start (0 is legal)
//     in_data    float operand
//     in_valid   in_data valid
//     in_ready   controller accepts in_data this cycle (registered)
//     out_data   accumulated float result (registered)
//     out_valid  result valid, held until out_ready
//     out_ready  downstream accepts result
//     busy       high in any state other than IDLE
//     bias       (FLOAT_ACC_BIAS_EN only) float added after the last element
//
//   State table
//     IDLE  | waiting for start
//     ACCUM | accepting operands, acc <= acc + in_data
//     BIAS  | (FLOAT_ACC_BIAS_EN) acc <= acc + bias_r
//     DONE  | presenting result until out_ready

module float_add (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    // Truncating adder: there is no rounding and no NaN/Inf handling.
    // An exponent of zero is treated as zero. This gives the bypass 0 + x = x
    // that the accumulator relies on for its cleared initial value.
    logic        swap;
    logic [31:0] l, s;
    logic [7:0]  el, es, d;
    logic [23:0] ml, ms, ms_al;
    logic [24:0] sum;
    logic [23:0] diff;
    logic [22:0] diff_sh;
    logic [4:0]  lz;

    always_comb begin
        swap    = (b[30:0] > a[30:0]);
        l       = swap ? b : a;
        s       = swap ? a : b;
        el      = l[30:23];
        es      = s[30:23];
        d       = el - es;
        ml      = {1'b1, l[22:0]};
        ms      = {1'b1, s[22:0]};
        ms_al   = (d > 8'd23) ? 24'h0 : (ms >> d);
        sum     = {1'b0, ml} + {1'b0, ms_al};
        diff    = ml - ms_al;
        lz      = 5'd0;
        // Ascending scan, so the highest set bit determines the shift.
        for (int i = 0; i < 24; i++) begin
            if (diff[i]) lz = 5'(23 - i);
        end
        diff_sh = 23'(diff << lz);
        y       = 32'h0;

        if (a[30:23] == 8'h00) begin
            y = b;
        end else if (b[30:23] == 8'h00) begin
            y = a;
        end else if (l[31] == s[31]) begin
            if (sum[24]) begin
                if (el == 8'hFE) y = {l[31], 8'hFF, 23'h0};
                else             y = {l[31], el + 8'd1, sum[23:1]};
            end else begin
                y = {l[31], el, sum[22:0]};
            end
        end else begin
            if (diff == 24'h0 || {3'b000, lz} >= el) y = 32'h0;
            else                                     y = {l[31], el - {3'b000, lz}, diff_sh};
        end
    end
endmodule

module float_acc_ctrl #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
`ifdef FLOAT_ACC_BIAS_EN
    ,
    input  logic [31:0]      bias
`endif
);

`ifdef FLOAT_ACC_BIAS_EN
    typedef enum logic [1:0] {IDLE, ACCUM, BIAS, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
`endif

    state_t           state;
    logic [31:0]      acc;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_r;
    logic [31:0]      add_b;
    logic [31:0]      add_y;

`ifdef FLOAT_ACC_BIAS_EN
    logic [31:0]      bias_r;
    // A single adder is shared; its second operand switches to bias in BIAS.
    assign add_b = (state == BIAS) ? bias_r : in_data;
`else
    assign add_b = in_data;
`endif

    float_add u_add (
        .a (acc),
        .b (add_b),
        .y (add_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= 32'h0;
            cnt       <= '0;
            len_r     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 32'h0;
            busy      <= 1'b0;
`ifdef FLOAT_ACC_BIAS_EN
            bias_r    <= 32'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= 32'h0;
                        cnt   <= '0;
                        len_r <= len;
                        busy  <= 1'b1;
`ifdef FLOAT_ACC_BIAS_EN
                        bias_r <= bias;
`endif
                        if (len == '0) begin
`ifdef FLOAT_ACC_BIAS_EN
                            state     <= BIAS;
`else
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= 32'h0;
`endif
                        end else begin
                            state    <= ACCUM;
                            in_ready <= 1'b1;
                        end
                    end
                end

                ACCUM: begin
                    if (in_valid && in_ready) begin
                        acc <= add_y;
                        cnt <= cnt + 1'b1;
                        if (cnt == len_r - LEN_W'(1)) begin
                            in_ready <= 1'b0;
`ifdef FLOAT_ACC_BIAS_EN
                            state     <= BIAS;
`else
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= add_y;
`endif
                        end
                    end
                end

`ifdef FLOAT_ACC_BIAS_EN
                BIAS: begin
                    acc       <= add_y;
                    out_data  <= add_y;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
`endif

                DONE: begin
                    // A start arriving with out_ready is dropped; it must be re-issued in IDLE.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_float_acc_ctrl.sv
module tb_float_acc_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] len;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
`ifdef FLOAT_ACC_BIAS_EN
    logic [31:0] bias;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    float_acc_ctrl #(.LEN_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef FLOAT_ACC_BIAS_EN
        ,
        .bias      (bias)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = 16'd0; in_data = 32'h0;
        in_valid = 1'b0; out_ready = 1'b0;
`ifdef FLOAT_ACC_BIAS_EN
        bias = 32'h0;
`endif
        tick(); tick();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'b0, in_ready},  32'd0);
        check("rst_busy",      {31'b0, busy},      32'd0);
        check("rst_out_data",  out_data,           32'h0);
        rst = 1'b0;
        tick();

        // 1: len=3, 1.0 + 2.0 + 0.5 = 3.5
        out_ready = 1'b1;
        start = 1'b1; len = 16'd3;
        tick();
        start = 1'b0;
        check("t1_in_ready", {31'b0, in_ready}, 32'd1);
        check("t1_busy",     {31'b0, busy},     32'd1);
        in_valid = 1'b1; in_data = 32'h3F800000; tick();
        in_data = 32'h40000000; tick();
        check("t1_no_early_valid", {31'b0, out_valid}, 32'd0);
        in_data = 32'h3F000000; tick();
        in_valid = 1'b0;
        check("t1_out_valid", {31'b0, out_valid}, 32'd1);
        check("t1_out_data",  out_data,           32'h40600000);
        check("t1_in_ready_done", {31'b0, in_ready}, 32'd0);
        tick();
        check("t1_busy_after", {31'b0, busy},      32'd0);
        check("t1_valid_after", {31'b0, out_valid}, 32'd0);

        // 2: len=2 with a 3-cycle stall, 3.0 + -1.0 = 2.0
        start = 1'b1; len = 16'd2;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'h40400000; tick();
        in_valid = 1'b0; in_data = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            check("t2_gap_in_ready", {31'b0, in_ready}, 32'd1);
            check("t2_gap_cnt", {16'b0, dut.cnt}, 32'd1);
            tick();
        end
        in_valid = 1'b1; in_data = 32'hBF800000; tick();
        in_valid = 1'b0;
        check("t2_out_valid", {31'b0, out_valid}, 32'd1);
        check("t2_out_data",  out_data,           32'h40000000);
        tick();
        check("t2_idle", {31'b0, busy}, 32'd0);

        // 3: len=0 goes straight to DONE with a zero result
        start = 1'b1; len = 16'd0;
        tick();
        start = 1'b0;
`ifndef FLOAT_ACC_BIAS_EN
        check("t3_in_ready",  {31'b0, in_ready},  32'd0);
        check("t3_out_valid", {31'b0, out_valid}, 32'd1);
        check("t3_out_data",  out_data,           32'h0);
        tick();
`else
        check("t3_in_ready_bias", {31'b0, in_ready}, 32'd0);
        tick();
        check("t3_out_valid", {31'b0, out_valid}, 32'd1);
        check("t3_out_data",  out_data,           32'h0);
        tick();
`endif
        check("t3_idle", {31'b0, busy}, 32'd0);

        // 4: len=1 result held under back-pressure; start is ignored in DONE
        out_ready = 1'b0;
        start = 1'b1; len = 16'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'h3F800000; tick();
        in_valid = 1'b0;
`ifdef FLOAT_ACC_BIAS_EN
        tick();
`endif
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", {31'b0, out_valid}, 32'd1);
            check("t4_hold_data",  out_data,           32'h3F800000);
            start = (i == 2); len = 16'd5;
            tick();
        end
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        check("t4_release_busy",  {31'b0, busy},      32'd0);
        check("t4_release_valid", {31'b0, out_valid}, 32'd0);
        tick();
        check("t4_start_dropped", {31'b0, busy}, 32'd0);

        // 5: reset mid-accumulation discards the partial sum
        start = 1'b1; len = 16'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'h40400000; tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        check("t5_busy",      {31'b0, busy},      32'd0);
        check("t5_out_valid", {31'b0, out_valid}, 32'd0);
        check("t5_in_ready",  {31'b0, in_ready},  32'd0);
        start = 1'b1; len = 16'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'h40000000; tick();
        in_valid = 1'b0;
`ifdef FLOAT_ACC_BIAS_EN
        tick();
`endif
        check("t5_fresh_valid", {31'b0, out_valid}, 32'd1);
        check("t5_fresh_data",  out_data,           32'h40000000);
        tick();

        // 6: negative magnitude-dominant sum, 1.0 + -3.0 = -2.0
        start = 1'b1; len = 16'd2;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'h3F800000; tick();
        in_data = 32'hC0400000; tick();
        in_valid = 1'b0;
`ifdef FLOAT_ACC_BIAS_EN
        tick();
`endif
        check("t6_neg_data", out_data, 32'hC0000000);
        tick();

`ifdef FLOAT_ACC_BIAS_EN
        // 7: bias 0.5 + 1.0 + 2.0 = 3.5, valid two cycles after last accept
        bias = 32'h3F000000;
        start = 1'b1; len = 16'd2;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'h3F800000; tick();
        in_data = 32'h40000000; tick();
        in_valid = 1'b0;
        check("t7_bias_not_yet", {31'b0, out_valid}, 32'd0);
        check("t7_bias_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        check("t7_bias_valid", {31'b0, out_valid}, 32'd1);
        check("t7_bias_data",  out_data,           32'h40600000);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/float_acc_ctrl.md
Name: float_acc_ctrl

Overview:
- Sequencing controller that streams a vector of IEEE-754 single-precision values through one shared combinational Float_Add instance and returns the sum.
- Accumulates one operand per cycle.
- Used by the convolution and detection-head stages for partial-sum reduction: channel sums, bias-ready dot products.
- Owns the accumulator register, element counter, FSM and valid/ready handshakes around the adder.

Parameters:
- LEN_W, 16, width of the vector-length input; maximum vector length is 2^LEN_W - 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle request to begin a new accumulation; sampled only in IDLE.
- len  input  LEN_W  number of elements to sum; sampled with start.
- in_data  input  32  float operand.
- in_valid  input  1  in_data valid.
- in_ready  output  1  controller accepts in_data this cycle.
- out_data  output  32  accumulated float result.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  downstream accepts result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset: state=IDLE; acc=32'h0; cnt=0; out_valid=0; in_ready=0; busy=0; out_data=32'h0.
- FSM states: IDLE, ACCUM, DONE (plus BIAS when the optional feature is enabled).
- IDLE:
  - On start=1: acc<=0, cnt<=0, latch len into len_r.
  - If len==0, go to DONE; otherwise go to ACCUM.
- ACCUM:
  - in_ready=1.
  - On in_valid&&in_ready: acc <= Float_Add(acc, in_data); cnt<=cnt+1.
  - When the accepted element is number len_r (cnt==len_r-1 at accept), go to DONE next cycle.
  - in_valid=0 stalls indefinitely with no state change.
- DONE:
  - out_valid=1 and out_data=acc; both are stable while out_ready=0.
  - On out_ready=1: go to IDLE, out_valid<=0.
- Throughput and latency:
  - One element accepted per cycle.
  - out_valid rises on the cycle after the last accept.
  - Minimum len=N transaction is N+2 cycles from start to IDLE when out_ready is held high.
- start is ignored outside IDLE. start and out_ready arriving together in DONE: only out_ready acts; start must be re-issued in IDLE.
- in_ready=0 in IDLE and DONE; in_data is ignored there.
- Arithmetic:
  - All arithmetic is delegated to Float_Add; no rounding, NaN or Inf handling is added.
  - The initial acc=0 relies on the adder's zero bypass: 0+x=x.
- Counter: cnt is LEN_W bits and never wraps, since len_r is at most 2^LEN_W-1.
- Reset mid-operation (ACCUM or DONE): return to IDLE immediately and discard the partial sum; out_valid drops on the next edge.
- The adder's combinational path runs acc -> Float_Add -> acc; there is no extra pipeline register.

Optional Feature:
- Macro: FLOAT_ACC_BIAS_EN.
- When defined:
  - Adds input port bias (32 bits), sampled with start.
  - Adds state BIAS between ACCUM (or IDLE when len==0) and DONE.
  - In BIAS, acc <= Float_Add(acc, bias_r) in one cycle; in_ready=0.
  - Result latency grows by one cycle.
- When undefined: no bias port, no BIAS state; behaviour is exactly as above.

Test Plan:
1. Reset, then start with len=3; feed 32'h3F800000, 32'h40000000, 32'h3F000000 back-to-back with out_ready=1 -> out_valid one cycle after the 3rd accept, out_data=32'h40600000 (3.5); busy low the following cycle.
2. start with len=2; feed 32'h40400000 then 32'hBF800000 with in_valid deasserted for 3 cycles between them -> in_ready held high during the gap, cnt unchanged, out_data=32'h40000000 (2.0).
3. start with len=0 -> DONE on the next cycle, out_data=32'h0, no in_ready pulse.
4. Complete len=1 with 32'h3F800000, holding out_ready=0 for 5 cycles -> out_valid and out_data=32'h3F800000 stable; pulsing start during this window has no effect; out_ready=1 -> IDLE.
5. Assert rst for one cycle after 2 of 4 elements accepted -> IDLE, out_valid=0, busy=0; a fresh len=1 run with 32'h40000000 yields 32'h40000000 (no stale partial sum).
6. With FLOAT_ACC_BIAS_EN defined, bias=32'h3F000000, len=2, elements 32'h3F800000 and 32'h40000000 -> out_data=32'h40600000, out_valid two cycles after the last accept.
